// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
// Parallel-to-serial stage that feeds the serial input of the sequence
// detector. Each WIDTH-bit word is taken over a valid/ready handshake and
// shifted out MSB-first, one bit per CLK. Between words x_out holds IDLE_BIT
// so that idle gaps cannot complete a detector pattern.
//
// Optional feature: define SEQ_SERIALIZER_PARITY_EN to append an even-parity
// bit after the LSB. Each word then takes WIDTH+1 cycles.
//
// Ports:
//   CLK         rising-edge clock
//   RESET       synchronous reset, active-high
//   din         parallel word to send
//   din_valid   din holds a word to send
//   din_ready   a word can be accepted this cycle (from state only)
//   x_out       serial bit stream (registered)
//   x_valid     x_out carries a data or parity bit (registered)
//   last_bit    x_out carries the final bit of the current word (registered)
//   busy        a word is being shifted out
//   words_sent  count of fully transmitted words, wraps silently
//
// state  | meaning
// IDLE   | nothing shifting, x_out = IDLE_BIT
// SHIFT  | data bits going out, MSB first
// PARITY | parity bit going out (SEQ_SERIALIZER_PARITY_EN only)
module seq_bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1,
  parameter int   CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int             BCW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, next_state;
  // The MSB goes straight to x_out on load, so only the remaining bits are kept.
  logic [WIDTH-2:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic             lsb_cycle;
  logic             word_end;
  logic             accept;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             parity;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = SHIFT;
      SHIFT: begin
        if (lsb_cycle) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
          next_state = PARITY;
`else
          next_state = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SEQ_SERIALIZER_PARITY_EN
      PARITY: next_state = accept ? SHIFT : IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // word_end marks the cycle carrying the final bit of a word; a new word may
  // be accepted there so back-to-back words need no bubble.
  always_comb begin
    lsb_cycle = (state == SHIFT) && (bit_cnt == LAST_IDX);
`ifdef SEQ_SERIALIZER_PARITY_EN
    word_end  = (state == PARITY);
`else
    word_end  = lsb_cycle;
`endif
    din_ready = (state == IDLE) || word_end;
    busy      = (state != IDLE);
    accept    = din_valid && din_ready;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      x_out      <= IDLE_BIT;
      x_valid    <= 1'b0;
      last_bit   <= 1'b0;
      words_sent <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      if (word_end) words_sent <= words_sent + 1'b1;

      if (accept) begin
        shreg    <= din[WIDTH-2:0];
        x_out    <= din[WIDTH-1];
        x_valid  <= 1'b1;
        last_bit <= 1'b0;
        bit_cnt  <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        parity   <= ^din;
`endif
      end else if ((state == SHIFT) && !lsb_cycle) begin
        shreg    <= shreg << 1;
        x_out    <= shreg[WIDTH-2];
        x_valid  <= 1'b1;
        bit_cnt  <= bit_cnt + 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
        last_bit <= 1'b0;
`else
        last_bit <= (bit_cnt == LAST_IDX - 1'b1);
`endif
`ifdef SEQ_SERIALIZER_PARITY_EN
      end else if (lsb_cycle) begin
        x_out    <= parity;
        x_valid  <= 1'b1;
        last_bit <= 1'b1;
`endif
      end else begin
        x_out    <= IDLE_BIT;
        x_valid  <= 1'b0;
        last_bit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

  localparam int W = 8;
`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int WLEN = W + 1;
`else
  localparam int WLEN = W;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, x_out, x_valid, last_bit, busy;
  logic [7:0]   words_sent;
  logic         w_din_ready, w_x_out, w_x_valid, w_last_bit, w_busy;
  logic [1:0]   w_words;

  int total = 0;
  int bad = 0;
  int exp_words = 0;

  seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x_out(x_out), .x_valid(x_valid),
    .last_bit(last_bit), .busy(busy), .words_sent(words_sent)
  );

  // Same stimulus, 2-bit counter, to observe wrap-around cheaply.
  seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .CNT_W(2)) u_wrap (
    .CLK(CLK), .RESET(RESET), .din(din), .din_valid(din_valid),
    .din_ready(w_din_ready), .x_out(w_x_out), .x_valid(w_x_valid),
    .last_bit(w_last_bit), .busy(w_busy), .words_sent(w_words)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (WLEN) step();
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    din_valid = 1'b0;
    step();
    step();
    RESET = 1'b0;
    exp_words = 0;
    total++; if (x_out !== 1'b1) begin bad++; $display("FAIL reset_x_out got=%b exp=1", x_out); end
    total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL reset_x_valid got=%b exp=0", x_valid); end
    total++; if (last_bit !== 1'b0) begin bad++; $display("FAIL reset_last_bit got=%b exp=0", last_bit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
    total++; if (words_sent !== 8'd0) begin bad++; $display("FAIL reset_words got=%0d exp=0", words_sent); end
  endtask

  task automatic test_single;
    logic [7:0] w;
    logic       e;
    w = 8'hA4;
    din = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      e = w[8-c];
      total++; if (x_out !== e) begin bad++; $display("FAIL single_x_out c=%0d got=%b exp=%b", c, x_out, e); end
      total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL single_x_valid c=%0d got=%b exp=1", c, x_valid); end
      e = (c == 8);
      total++; if (last_bit !== e) begin bad++; $display("FAIL single_last_bit c=%0d got=%b exp=%b", c, last_bit, e); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=1", c, busy); end
      step();
    end
    exp_words++;
    total++; if (x_out !== 1'b1) begin bad++; $display("FAIL single_idle_x_out got=%b exp=1", x_out); end
    total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL single_idle_x_valid got=%b exp=0", x_valid); end
    total++; if (last_bit !== 1'b0) begin bad++; $display("FAIL single_idle_last_bit got=%b exp=0", last_bit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    total++; if (words_sent !== 8'(exp_words)) begin bad++; $display("FAIL single_words got=%0d exp=%0d", words_sent, exp_words); end
  endtask

  task automatic test_back_to_back;
    logic e;
    din = 8'hFF;
    din_valid = 1'b1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready c=0 got=%b exp=1", din_ready); end
    step();
    din = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      e = (c <= 8);
      total++; if (x_out !== e) begin bad++; $display("FAIL b2b_x_out c=%0d got=%b exp=%b", c, x_out, e); end
      total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL b2b_x_valid c=%0d got=%b exp=1", c, x_valid); end
      if (c < 16) begin
        e = (c == 8);
        total++; if (din_ready !== e) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, din_ready, e); end
      end
      step();
      if (c == 8) din_valid = 1'b0;
    end
    exp_words += 2;
    total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_x_valid got=%b exp=0", x_valid); end
    total++; if (words_sent !== 8'(exp_words)) begin bad++; $display("FAIL b2b_words got=%0d exp=%0d", words_sent, exp_words); end
  endtask

  task automatic test_backpressure;
    logic [7:0] w0, w1;
    logic       e, ev;
    w0 = 8'h5A;
    w1 = 8'h96;
    din = w0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din = 8'hFF;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) begin din = w1; din_valid = 1'b1; end
      if (c == 9) begin din_valid = 1'b0; din = 8'h00; end
      if (c <= 8)       begin e = w0[8-c];  ev = 1'b1; end
      else if (c <= 16) begin e = w1[16-c]; ev = 1'b1; end
      else              begin e = 1'b1;     ev = 1'b0; end
      total++; if (x_out !== e) begin bad++; $display("FAIL bp_x_out c=%0d got=%b exp=%b", c, x_out, e); end
      total++; if (x_valid !== ev) begin bad++; $display("FAIL bp_x_valid c=%0d got=%b exp=%b", c, x_valid, ev); end
      step();
    end
    exp_words += 2;
    total++; if (words_sent !== 8'(exp_words)) begin bad++; $display("FAIL bp_words got=%0d exp=%0d", words_sent, exp_words); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] w;
    din = 8'hC3;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (3) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    exp_words = 0;
    total++; if (x_out !== 1'b1) begin bad++; $display("FAIL rmid_x_out got=%b exp=1", x_out); end
    total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL rmid_x_valid got=%b exp=0", x_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (words_sent !== 8'd0) begin bad++; $display("FAIL rmid_words got=%0d exp=0", words_sent); end
    w = 8'h81;
    din = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++; if (x_out !== w[8-c]) begin bad++; $display("FAIL rmid_resend_x_out c=%0d got=%b exp=%b", c, x_out, w[8-c]); end
      step();
    end
    exp_words++;
    total++; if (words_sent !== 8'(exp_words)) begin bad++; $display("FAIL rmid_resend_words got=%0d exp=%0d", words_sent, exp_words); end
  endtask

  // Small "100" detector model fed by x_out; idle 1s must never complete it.
  task automatic test_detector;
    logic [2:0] hist;
    int hits, hitc;
    hist = 3'b111;
    hits = 0;
    hitc = -1;
    din = 8'hF0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      hist = {hist[1:0], x_out};
      if (hist == 3'b100) begin hits++; hitc = c; end
      step();
    end
    exp_words++;
    total++; if (hits !== 1) begin bad++; $display("FAIL det_hits got=%0d exp=1", hits); end
    total++; if (hitc !== 6) begin bad++; $display("FAIL det_cycle got=%0d exp=6", hitc); end
  endtask

  task automatic test_wrap;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hFF);
    total++; if (w_words !== 2'd3) begin bad++; $display("FAIL wrap_three got=%0d exp=3", w_words); end
    total++; if (words_sent !== 8'd3) begin bad++; $display("FAIL wrap_main_three got=%0d exp=3", words_sent); end
    send_word(8'h12);
    total++; if (w_words !== 2'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", w_words); end
    total++; if (words_sent !== 8'd4) begin bad++; $display("FAIL wrap_main_four got=%0d exp=4", words_sent); end
  endtask

`ifdef SEQ_SERIALIZER_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic [8:0] exps  [2];
    logic [8:0] ev;
    logic       e;
    words[0] = 8'h07; exps[0] = 9'b000001111;
    words[1] = 8'h03; exps[1] = 9'b000000110;
    for (int k = 0; k < 2; k++) begin
      ev = exps[k];
      din = words[k];
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        total++; if (x_out !== ev[9-c]) begin bad++; $display("FAIL par_x_out w=%0d c=%0d got=%b exp=%b", k, c, x_out, ev[9-c]); end
        total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL par_x_valid w=%0d c=%0d got=%b exp=1", k, c, x_valid); end
        e = (c == 9);
        total++; if (last_bit !== e) begin bad++; $display("FAIL par_last_bit w=%0d c=%0d got=%b exp=%b", k, c, last_bit, e); end
        total++; if (din_ready !== e) begin bad++; $display("FAIL par_ready w=%0d c=%0d got=%b exp=%b", k, c, din_ready, e); end
        step();
      end
      exp_words++;
      total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL par_idle w=%0d got=%b exp=0", k, x_valid); end
      total++; if (words_sent !== 8'(exp_words)) begin bad++; $display("FAIL par_words w=%0d got=%0d exp=%0d", k, words_sent, exp_words); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEQ_SERIALIZER_PARITY_EN
    test_parity();
`else
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_detector();
`endif
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial stage that feeds the serial input of the team's FSM sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per CLK, on x_out. Between words it drives a configurable idle level so that gaps cannot fabricate a detector pattern. The word boundary is marked by x_valid and last_bit for bench and debug use.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32
IDLE_BIT, 1'b1, level on x_out whenever no word is shifting; 1 so that idle gaps cannot complete a "...00" tail
CNT_W, 8, width of the words_sent counter

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous reset, active-high
din  input  WIDTH  parallel word to send
din_valid  input  1  din holds a word to send
din_ready  output  1  stage can accept a word this cycle (combinational from state only)
x_out  output  1  serial bit stream (registered); connects to detector x
x_valid  output  1  x_out carries a data or parity bit (registered)
last_bit  output  1  x_out carries the final bit of the current word (registered)
busy  output  1  state != IDLE
words_sent  output  CNT_W  count of fully transmitted words; wraps modulo 2^CNT_W

Behaviour:
- All registers are updated only on posedge CLK. RESET is sampled at the edge and has priority over all other activity.
- Reset values: state=IDLE, x_out=IDLE_BIT, x_valid=0, last_bit=0, bit_cnt=0, shift register=0, words_sent=0. After reset, din_ready=1.
- States:
  - IDLE: nothing shifting.
  - SHIFT: data bits going out.
  - PARITY: exists only with the optional feature enabled.
- din_ready=1 in IDLE, and also in the cycle x_out shows the final bit of a word. This gives zero-bubble back-to-back transfers.
- Accept happens when din_valid && din_ready at a clock edge. Once accepted, din may change freely.
- Latency: for a word accepted at edge k, x_out=din[WIDTH-1] during cycle k+1. Bit i appears in cycle k+1+(WIDTH-1-i), so the LSB appears in cycle k+WIDTH.
- Transitions:
  - IDLE to SHIFT on accept. The register loads din, x_out takes the MSB, x_valid=1, bit_cnt=0.
  - SHIFT with bit_cnt<WIDTH-1: shift left, x_out takes the next bit, bit_cnt increments.
  - SHIFT with bit_cnt==WIDTH-1 (last_bit=1): words_sent increments. If a new word is accepted at this edge, stay in SHIFT and load it. Otherwise go to IDLE: x_out=IDLE_BIT, x_valid=0.
- last_bit=1 exactly in the cycle that carries the final bit of a word (the LSB, or the parity bit when enabled).
- din_valid while din_ready=0: no action. The source must hold din and din_valid; nothing is dropped or duplicated.
- RESET mid-word: the word in flight is abandoned, words_sent is not incremented, and x_out returns to IDLE_BIT on the next edge.
- words_sent: incremented at the edge that ends the last bit of a word. It wraps from 2^CNT_W-1 to 0 with no flag.
- busy=1 in SHIFT and PARITY, and 0 in IDLE.

Optional Feature:
Macro SEQ_SERIALIZER_PARITY_EN.
- Defined:
  - After the LSB, the block enters PARITY for one cycle. x_out carries the even parity bit (XOR of the word), x_valid=1, last_bit=1.
  - din_ready moves from the LSB cycle to the PARITY cycle.
  - Words occupy WIDTH+1 cycles, and words_sent increments at the end of PARITY.
- Undefined: the PARITY state, the parity register and the XOR logic are absent. Behaviour is exactly as in Behaviour.

Test Plan:
- Single word, no macro: reset, then din=8'hA4 accepted at edge 0. Expect x_out = 1,0,1,0,0,1,0,0 in cycles 1..8; last_bit=1 only in cycle 8; then x_out=1 with x_valid=0; words_sent=1.
- Back-to-back: din_valid held high with 8'hFF then 8'h00. Expect 16 consecutive x_valid cycles with no idle bit between words; din_ready high in cycles 0 and 8 only; words_sent=2.
- Backpressure: din_valid asserted while busy and held for 5 cycles. Expect the word accepted only at the LSB-cycle edge, transmitted exactly once.
- Reset mid-word: assert RESET during bit 3 of 8'hC3. Expect x_out=IDLE_BIT, x_valid=0, words_sent=0 on the next edge; a new word sends normally afterwards.
- Detector integration: serializer output drives the sequence detector; send 8'hF0 followed by idle. Expect the detector to raise z only during the "100" run inside the word, and never during idle.
- Parity (SEQ_SERIALIZER_PARITY_EN defined): send 8'h07. Expect 9 valid bits 0,0,0,0,0,1,1,1,1 with the parity bit last; send 8'h03 and expect parity 0; wrap test with CNT_W=2 gives words_sent 3 then 0.
